// File: rtl/sigma_delta_adc_scan_ctrl.sv
// sigma_delta_adc_scan_ctrl: scans NCH channels through one shared decimator (SD_SCAN_AVG_EN averages 2**AVG_LOG2 samples)
module sigma_delta_adc_scan_ctrl #(
  parameter int NCH = 4,
  parameter int WDTH = 22,
  parameter int DISCARD = 2,
  parameter int AVG_LOG2 = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            continuous,
  input  logic [NCH-1:0]  chan_mask,
  output logic [CW-1:0]   chan_sel,
  output logic            dec_clr,
  input  logic [WDTH-1:0] dec_data,
  input  logic            dec_valid,
  output logic [WDTH-1:0] out_data,
  output logic [CW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);
  localparam int SW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  typedef enum logic [2:0] {IDLE, SWITCH, SETTLE, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [NCH-1:0] mask_r, mask_n;
  logic [CW-1:0] sel_n, lo_new, lo_hi;
  logic has_hi, done, settle_last;
  logic [SW-1:0] settle_cnt;
  logic [WDTH-1:0] cap_data;
`ifdef SD_SCAN_AVG_EN
  localparam int AW = WDTH + AVG_LOG2;
  logic [AW-1:0] acc, acc_sum;
  logic [AVG_LOG2:0] avg_cnt;
  assign acc_sum = acc + AW'(dec_data);
  assign done = dec_valid && (int'(avg_cnt) == (1 << AVG_LOG2) - 1);
  assign cap_data = WDTH'(acc_sum >> AVG_LOG2);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      avg_cnt <= '0;
    end else begin
      acc <= (state != CAPTURE) ? '0 : dec_valid ? acc_sum : acc;
      avg_cnt <= (state != CAPTURE) ? '0 : dec_valid ? avg_cnt + 1 : avg_cnt;
    end
`else
  logic unused_avg;
  assign unused_avg = ^AVG_LOG2;
  assign done = dec_valid;
  assign cap_data = dec_data;
`endif
  assign busy = state != IDLE;
  assign dec_clr = state == SWITCH;
  assign out_valid = state == HOLD;
  assign settle_last = dec_valid && (int'(settle_cnt) == DISCARD - 1);
  // lowest enabled bit of the live mask, and next enabled bit above the current channel
  always_comb begin
    lo_new = '0;
    lo_hi = '0;
    has_hi = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chan_mask[i]) lo_new = CW'(i);
      if (mask_r[i] && i > int'(chan_sel)) begin
        lo_hi = CW'(i);
        has_hi = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    sel_n = chan_sel;
    mask_n = mask_r;
    case (state)
      IDLE: if (!stop && start && |chan_mask) begin
        state_n = SWITCH;
        mask_n = chan_mask;
        sel_n = lo_new;
      end
      SWITCH: state_n = stop ? IDLE : (DISCARD == 0) ? CAPTURE : SETTLE;
      SETTLE: state_n = stop ? IDLE : settle_last ? CAPTURE : SETTLE;
      CAPTURE: state_n = stop ? IDLE : done ? HOLD : CAPTURE;
      HOLD: if (out_ready) begin
        state_n = (has_hi || (continuous && |chan_mask)) ? SWITCH : IDLE;
        sel_n = has_hi ? lo_hi : (continuous && |chan_mask) ? lo_new : chan_sel;
        mask_n = (!has_hi && continuous) ? chan_mask : mask_r;
        if (stop) state_n = IDLE;
      end else if (stop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chan_sel <= '0;
      mask_r <= '0;
      settle_cnt <= '0;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      chan_sel <= sel_n;
      mask_r <= mask_n;
      settle_cnt <= (state == SWITCH) ? '0 : (state == SETTLE && dec_valid) ? settle_cnt + 1 : settle_cnt;
      if (state == CAPTURE && done) begin
        out_data <= cap_data;
        out_chan <= chan_sel;
      end
    end
endmodule

// File: tb/tb_sigma_delta_adc_scan_ctrl.sv
// tb_sigma_delta_adc_scan_ctrl: scoreboard bench with a free-running decimator model (strobe every 8 clks, data=16*chan+k)
module tb_sigma_delta_adc_scan_ctrl;
  localparam int WDTH = 22;
`ifdef SD_SCAN_AVG_EN
  localparam int EK = 3;
`else
  localparam int EK = 2;
`endif
  logic clk = 0, rst = 1, start = 0, stop = 0, continuous = 0, out_ready = 0;
  logic [3:0] chan_mask = '0;
  logic [1:0] chan_sel, out_chan;
  logic dec_clr, dec_valid, out_valid, busy;
  logic [WDTH-1:0] dec_data, out_data;
  always #5 clk = ~clk;

  sigma_delta_adc_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .chan_mask(chan_mask), .chan_sel(chan_sel), .dec_clr(dec_clr), .dec_data(dec_data),
    .dec_valid(dec_valid), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  logic [2:0] ph = '0;
  int k = 0;
  assign dec_valid = ph == 3'd7;
  assign dec_data = WDTH'(16 * int'(chan_sel) + k);
  always @(posedge clk)
    if (dec_clr) begin
      ph <= '0;
      k <= 0;
    end else begin
      ph <= ph + 3'd1;
      if (dec_valid) k <= k + 1;
    end

  typedef struct {int ch; int d;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int clr_q[$];
  int checks = 0, failures = 0, n_out = 0;

  always @(negedge clk) begin
    if (dec_clr) clr_q.push_back(int'(chan_sel));
    if (out_valid && out_ready && !rst) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out chan=%0d data=%0d required=none", out_chan, out_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_chan) !== e.ch || int'(out_data) !== e.d) begin
          failures++;
          $display("FAIL result chan=%0d data=%0d required chan=%0d data=%0d", out_chan, out_data, e.ch, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_busy_low(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy=%0b required=0 after %0d cycles", nm, busy, n);
    end
  endtask

  task automatic wait_out_valid(input int budget, input string nm);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid=%0b required=1 after %0d cycles", nm, out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, out_valid, dec_clr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl busy/valid/clr=%b required=000", {busy, out_valid, dec_clr});
    end
    checks++;
    if ({chan_sel, out_chan} !== 4'b0) begin
      failures++;
      $display("FAIL reset_chan chan_sel=%0d out_chan=%0d required=0", chan_sel, out_chan);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data out_data=%0d required=0", out_data);
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single_scan();
    clr_q.delete();
    chan_mask = 4'b0101;
    continuous = 0;
    out_ready = 1;
    exp_q.push_back('{ch: 0, d: EK});
    exp_q.push_back('{ch: 2, d: 32 + EK});
    pulse_start();
    @(negedge clk);
    checks++;
    if ({busy, dec_clr} !== 2'b11 || chan_sel !== 2'd0) begin
      failures++;
      $display("FAIL switch_entry busy/clr=%b chan_sel=%0d required=11 sel=0", {busy, dec_clr}, chan_sel);
    end
    wait_busy_low(300, "single_done");
    @(negedge clk);
    checks++;
    if (clr_q.size() !== 2) begin
      failures++;
      $display("FAIL clr_count got=%0d required=2", clr_q.size());
    end else begin
      checks++;
      if (clr_q[0] !== 0 || clr_q[1] !== 2) begin
        failures++;
        $display("FAIL clr_chans got=%0d,%0d required=0,2", clr_q[0], clr_q[1]);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL single_results pending=%0d required=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    chan_mask = 4'b0001;
    exp_q.push_back('{ch: 0, d: EK});
    pulse_start();
    wait_out_valid(200, "bp_valid");
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== WDTH'(EK)) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%0b chan=%0d data=%0d required 1/0/%0d", i, out_valid, out_chan, out_data, EK);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release valid=%0b busy=%0b required=0/0", out_valid, busy);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_result pending=%0d required=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_continuous();
    int n = 0;
    out_ready = 1;
    continuous = 1;
    chan_mask = 4'b1000;
    exp_q.push_back('{ch: 3, d: 48 + EK});
    exp_q.push_back('{ch: 0, d: EK});
    exp_q.push_back('{ch: 1, d: 16 + EK});
    exp_q.push_back('{ch: 0, d: EK});
    exp_q.push_back('{ch: 1, d: 16 + EK});
    pulse_start();
    repeat (5) tick();
    chan_mask = 4'b0011;
    while (exp_q.size() != 0 && n < 800) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL cont_order pending=%0d required=0", exp_q.size());
    end
    stop = 1;
    tick();
    stop = 0;
    continuous = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_stop busy=%0b required=0", busy);
    end
    exp_q.delete();
  endtask

  task automatic test_stop();
    int n0;
    out_ready = 1;
    chan_mask = 4'b0001;
    n0 = n_out;
    pulse_start();
    repeat (3) tick();
    stop = 1;
    tick();
    stop = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_settle busy=%0b valid=%0b required=0/0", busy, out_valid);
    end
    repeat (60) tick();
    checks++;
    if (n_out !== n0) begin
      failures++;
      $display("FAIL stop_settle_out got=%0d required=%0d", n_out, n0);
    end
    out_ready = 0;
    pulse_start();
    wait_out_valid(200, "stop_hold_valid");
    stop = 1;
    tick();
    stop = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_hold busy=%0b valid=%0b required=0/0", busy, out_valid);
    end
    out_ready = 1;
    repeat (30) tick();
    checks++;
    if (n_out !== n0) begin
      failures++;
      $display("FAIL stop_hold_out got=%0d required=%0d", n_out, n0);
    end
    start = 1;
    stop = 1;
    tick();
    start = 0;
    stop = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_idle busy=%0b required=0", busy);
    end
  endtask

  task automatic test_mask_zero();
    chan_mask = 4'b0000;
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dec_clr !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero busy=%0b clr=%0b required=0/0", busy, dec_clr);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    chan_mask = 4'b0100;
    out_ready = 1;
    pulse_start();
    tick();
    while (k != 2 && n < 100) begin
      tick();
      n++;
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({busy, out_valid, dec_clr} !== 3'b000 || chan_sel !== 2'd0 || out_data !== '0 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL async_rst busy/valid/clr=%b sel=%0d data=%0d chan=%0d required all 0", {busy, out_valid, dec_clr}, chan_sel, out_data, out_chan);
    end
    tick();
    rst = 0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_release busy=%0b required=0", busy);
    end
  endtask

`ifdef SD_SCAN_AVG_EN
  logic a_start = 0, a_dv = 0;
  logic [3:0] a_mask = 4'b0001;
  logic [WDTH-1:0] a_dd = '0, a_od;
  logic [1:0] a_sel, a_oc;
  logic a_clr, a_ov, a_busy;
  sigma_delta_adc_scan_ctrl #(.DISCARD(0), .AVG_LOG2(2)) u_avg (
    .clk(clk), .rst(rst), .start(a_start), .stop(1'b0), .continuous(1'b0),
    .chan_mask(a_mask), .chan_sel(a_sel), .dec_clr(a_clr), .dec_data(a_dd),
    .dec_valid(a_dv), .out_data(a_od), .out_chan(a_oc), .out_valid(a_ov),
    .out_ready(1'b0), .busy(a_busy));

  task automatic test_avg();
    int vals[4] = '{10, 11, 12, 14};
    a_start = 1;
    tick();
    a_start = 0;
    tick();
    foreach (vals[i]) begin
      a_dv = 1;
      a_dd = WDTH'(vals[i]);
      tick();
      a_dv = 0;
      tick();
    end
    @(negedge clk);
    checks++;
    if (a_ov !== 1'b1 || a_od !== WDTH'(11)) begin
      failures++;
      $display("FAIL avg valid=%0b data=%0d required=1/11", a_ov, a_od);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_scan();
    test_backpressure();
    test_continuous();
    test_stop();
    test_mask_zero();
    test_async_reset();
`ifdef SD_SCAN_AVG_EN
    test_avg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sigma_delta_adc_scan_ctrl.md
Name: sigma_delta_adc_scan_ctrl

Overview:
- Scan sequencer that shares one sigma-delta ADC decimator among NCH analog channels. The shared decimator is the CIC path that emits a WDTH-bit result with a valid strobe every BOSR clocks.
- Drives the front-end mux select and clears the decimator on each channel switch.
- Discards CIC settling outputs, then captures a result per channel.
- Presents each result on a valid/ready stream tagged with its channel number.
- Sits between the comparator/decimator harness and the downstream sample consumer.

Parameters:
- NCH, 4, number of analog channels (>=2).
- WDTH, 22, decimator output width. Matches 2 + STGS*clog2(BOSR).
- DISCARD, 2, decimator outputs dropped after each switch. Set equal to STGS; 0 is legal.
- AVG_LOG2, 2, log2 of samples averaged per result. Used only with the optional feature.

Ports:
- clk  in  1  system clock (the BCLK domain).
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a scan.
- stop  in  1  abort: return to IDLE.
- continuous  in  1  1 = rescan forever; 0 = one scan per start.
- chan_mask  in  NCH  channel enables.
- chan_sel  out  CW  mux select, where CW = max(1, clog2(NCH)).
- dec_clr  out  1  decimator synchronous clear pulse.
- dec_data  in  WDTH  decimator result.
- dec_valid  in  1  decimator result strobe.
- out_data  out  WDTH  captured result.
- out_chan  out  CW  channel of out_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: chan_sel=0, dec_clr=0, out_data=0, out_chan=0, out_valid=0, busy=0, state=IDLE, internal mask register=0. Reset is asynchronous and may assert in any state; the FSM returns to IDLE with no output glitch after release.
- States: IDLE, SWITCH, SETTLE, CAPTURE, HOLD.
- IDLE:
  - start with chan_mask!=0 latches chan_mask into mask_r, selects the lowest set bit, and goes to SWITCH.
  - start with chan_mask==0 is ignored.
- SWITCH (exactly 1 cycle):
  - chan_sel takes the new channel on entry. dec_clr=1 for this cycle only.
  - dec_valid in this cycle is ignored.
  - Next state is SETTLE, or CAPTURE when DISCARD==0.
- SETTLE:
  - Counts dec_valid pulses; dec_data is ignored.
  - After the DISCARD-th pulse, goes to CAPTURE.
- CAPTURE:
  - On dec_valid, latches dec_data into out_data and chan_sel into out_chan.
  - Next cycle: out_valid=1 and state=HOLD.
- HOLD:
  - out_valid, out_data and out_chan stay stable until out_valid && out_ready. dec_valid is ignored, with no overrun flag.
  - On handshake, out_valid drops the next cycle and the next channel is chosen: the next set bit of mask_r above the current channel.
  - If no higher bit is set, the scan wraps:
    - continuous=0: go to IDLE.
    - continuous=1: reload mask_r from chan_mask and take its lowest set bit. If the reloaded mask is 0, go to IDLE.
  - Otherwise go to SWITCH. A single enabled channel still passes through SWITCH/SETTLE on every sample.
- chan_mask changes mid-scan are ignored until the wrap reload. start while busy is ignored.
- stop:
  - From any non-IDLE state, the next state is IDLE with out_valid=0; a pending HOLD sample is dropped.
  - stop and start in the same cycle in IDLE: stop wins and the FSM stays in IDLE.
  - stop in the same cycle as a HOLD handshake: the sample counts as delivered, then the FSM goes to IDLE.
- Latency from the start pulse to out_valid: 1 SWITCH cycle, plus waiting for DISCARD+1 dec_valid pulses, plus 1 cycle.
- Counters:
  - The settle counter width is clog2(DISCARD+1).
  - The channel search is combinational priority logic over mask_r, masked above the current index.

Optional Feature:
- Macro: SD_SCAN_AVG_EN.
- Defined: CAPTURE accumulates 2**AVG_LOG2 consecutive dec_valid samples in a WDTH+AVG_LOG2 bit unsigned accumulator, cleared on entry to CAPTURE.
  - out_data = acc >> AVG_LOG2, truncating.
  - out_valid rises the cycle after the last sample.
- Undefined: a single sample is captured and AVG_LOG2 is unused.

Test Plan:
- NCH=4, mask=4'b0101, continuous=0, out_ready=1, model decimator strobing every 8 clks with data=16*chan+k. Required:
  - dec_clr pulses twice, with chan_sel=0 then chan_sel=2.
  - Results (chan0, 3rd strobe after the clr) then (chan2, 3rd strobe).
  - Then IDLE with busy=0.
- Backpressure: hold out_ready=0 for 40 clks in HOLD. Required: out_data/out_chan stable, intervening dec_valid ignored, out_valid drops 1 cycle after ready rises.
- continuous=1, mask=4'b1000, change chan_mask to 4'b0011 mid-sample. Required: order 3, 0, 1, 0, 1…; the change takes effect only after the wrap.
- stop asserted in SETTLE and separately in HOLD. Required: IDLE next cycle, out_valid=0, no result emitted. Also start+stop together in IDLE leaves busy=0.
- start with mask=0: no state change, busy=0. Async rst asserted mid-CAPTURE: all outputs zero immediately.
- With SD_SCAN_AVG_EN and AVG_LOG2=2, DISCARD=0, decimator values 10, 11, 12, 14. Required: out_data=11.
